// File: rtl/apm_seq_pkg.sv
// apm_seq_pkg: APM mode encodings and sequencer state shared by the MAC sequencer.
package apm_seq_pkg;
    localparam logic [2:0] MODEY_MULT   = 3'b001;
    localparam logic [3:0] MODEZ_ZERO   = 4'b0000;
    localparam logic [3:0] MODEZ_PFB    = 4'b0001;
    localparam logic [4:0] MODEIN_XONLY = 5'b00010;
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, RESULT} state_t;
endpackage

// File: rtl/apm_tag_pipe.sv
// apm_tag_pipe: {v, first} delay line that tracks operands through the APM multiplier register.
module apm_tag_pipe
    import apm_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic CLK,
    input  logic arst_x,
    input  logic v_in,
    input  logic first_in,
    output logic v_out,
    output logic first_out
);
    if (DEPTH == 0) begin : g_wire
        assign v_out     = v_in;
        assign first_out = first_in;
    end else begin : g_reg
        always_ff @(posedge CLK or posedge arst_x) begin
            if (arst_x) begin
                v_out     <= 1'b0;
                first_out <= 1'b0;
            end else begin
                v_out     <= v_in;
                first_out <= first_in;
            end
        end
    end
endmodule

// File: rtl/apm_mac_seq.sv
// apm_mac_seq: drives one APM as a signed multiply-accumulate engine over a LEN-pair job.
module apm_mac_seq
    import apm_seq_pkg::*;
#(
    parameter int LEN_W    = 8,
    parameter int MULT_REG = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    input  logic             OP_VALID,
    output logic             OP_READY,
    input  logic [24:0]      OP_X,
    input  logic [17:0]      OP_Y,
    output logic [29:0]      APM_X,
    output logic [17:0]      APM_Y,
    output logic [2:0]       APM_MODEY,
    output logic [3:0]       APM_MODEZ,
    output logic [4:0]       APM_MODEIN,
    output logic             APM_CEM,
    output logic             APM_CEP,
    output logic             APM_RSTP,
    input  logic [47:0]      APM_P,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [47:0]      RES_DATA,
    output logic             BUSY
);
    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             first_pend;
    logic             accept;
    logic             zero_job;
    logic             tag_v;
    logic             tag_first;

    assign accept     = OP_VALID & OP_READY;
    // Clearing P combinationally lets an empty job report 0 on its first RESULT cycle.
    assign zero_job   = (state == IDLE) & START & (LEN == '0);
    assign APM_X      = accept ? {{5{OP_X[24]}}, OP_X} : '0;
    assign APM_Y      = accept ? OP_Y : '0;
    assign APM_MODEY  = MODEY_MULT;
    assign APM_MODEIN = MODEIN_XONLY;
    assign APM_CEM    = 1'b1;
    assign APM_CEP    = tag_v;
    assign APM_MODEZ  = tag_first ? MODEZ_ZERO : MODEZ_PFB;
    assign APM_RSTP   = RST | zero_job;
    assign RES_DATA   = APM_P;

    apm_tag_pipe #(.DEPTH(MULT_REG)) u_tag_pipe (
        .CLK       (CLK),
        .arst_x    (RST),
        .v_in      (accept),
        .first_in  (accept & first_pend),
        .v_out     (tag_v),
        .first_out (tag_first)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            remaining  <= '0;
            first_pend <= 1'b0;
            OP_READY   <= 1'b0;
            RES_VALID  <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    BUSY <= 1'b1;
                    if (LEN != '0) begin
                        remaining  <= LEN;
                        first_pend <= 1'b1;
                        OP_READY   <= 1'b1;
                        state      <= FEED;
                    end else begin
                        RES_VALID <= 1'b1;
                        state     <= RESULT;
                    end
                end
                FEED: if (accept) begin
                    remaining  <= remaining - LEN_W'(1);
                    first_pend <= 1'b0;
                    if (remaining == LEN_W'(1)) begin
                        OP_READY <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                // Wait until the last product has landed in P before presenting it.
                DRAIN: if (!tag_v) begin
                    RES_VALID <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: if (RES_READY) begin
                    RES_VALID <= 1'b0;
                    BUSY      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apm_mac_seq.sv
// tb_apm_mac_seq: drives MULT_REG=1 and MULT_REG=0 sequencers in lockstep, each with a behavioural APM.
module tb_apm_mac_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        op_valid;
    logic [24:0] op_x;
    logic [17:0] op_y;
    logic        res_ready;
    logic        op_ready [2];
    logic        res_valid [2];
    logic        busy [2];
    logic        apm_cem [2];
    logic        apm_cep [2];
    logic        apm_rstp [2];
    logic [29:0] apm_x [2];
    logic [17:0] apm_y [2];
    logic [2:0]  apm_modey [2];
    logic [3:0]  apm_modez [2];
    logic [4:0]  apm_modein [2];
    logic [47:0] apm_p [2];
    logic [47:0] res_data [2];
    logic [24:0] jx [8];
    logic [17:0] jy [8];
    logic [47:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [47:0] m_q, p_q, prod_now, prod_use;
        apm_mac_seq #(.LEN_W(8), .MULT_REG(g)) u_dut (
            .CLK(clk), .RST(rst), .START(start), .LEN(len),
            .OP_VALID(op_valid), .OP_READY(op_ready[g]), .OP_X(op_x), .OP_Y(op_y),
            .APM_X(apm_x[g]), .APM_Y(apm_y[g]), .APM_MODEY(apm_modey[g]),
            .APM_MODEZ(apm_modez[g]), .APM_MODEIN(apm_modein[g]), .APM_CEM(apm_cem[g]),
            .APM_CEP(apm_cep[g]), .APM_RSTP(apm_rstp[g]), .APM_P(apm_p[g]),
            .RES_VALID(res_valid[g]), .RES_READY(res_ready), .RES_DATA(res_data[g]),
            .BUSY(busy[g])
        );
        // APM model: optional multiplier register, then P = product or product + P.
        assign prod_now = $signed({{18{apm_x[g][29]}}, apm_x[g]}) * $signed({{30{apm_y[g][17]}}, apm_y[g]});
        assign prod_use = (g == 1) ? m_q : prod_now;
        always @(posedge clk) m_q <= prod_now;
        always @(posedge clk)
            if (apm_rstp[g]) p_q <= '0;
            else if (apm_cep[g])
                p_q <= (apm_modez[g] == 4'b0000) ? prod_use :
                       (apm_modez[g] == 4'b0001) ? prod_use + p_q : 'x;
        assign apm_p[g] = p_q;
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int n, input int gap, input int hold, input logic inject);
        longint      acc = 0;
        longint      pr;
        int          lat [2];
        logic [47:0] snap [2];
        for (int i = 0; i < n; i++) begin
            pr = longint'($signed(jx[i])) * longint'($signed(jy[i]));
            acc += pr;
        end
        exp_q.push_back(acc[47:0]);
        start = 1'b1;
        len   = n[7:0];
        if (n == 0) begin
            #1;
            for (int k = 0; k < 2; k++) chk("rstp_len0", apm_rstp[k], 1);
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < gap; b++) begin
                op_valid = 1'b0;
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    chk("cep_bubble", apm_cep[k], 0);
                    chk("apm_x_idle", apm_x[k], 0);
                    if (b == 0) snap[k] = apm_p[k];
                    else chk("p_hold_bubble", apm_p[k], snap[k]);
                end
            end
            for (int k = 0; k < 2; k++) chk("op_ready_feed", op_ready[k], 1);
            op_valid = 1'b1;
            op_x     = jx[i];
            op_y     = jy[i];
            #1;
            for (int k = 0; k < 2; k++) chk("apm_x_sext", apm_x[k], {18'd0, {5{jx[i][24]}}, jx[i]});
            @(negedge clk);
        end
        op_valid = 1'b0;
        op_x     = '0;
        op_y     = '0;
        lat      = '{99, 99};
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 2; k++) if (res_valid[k] && lat[k] == 99) lat[k] = t;
            if (lat[0] != 99 && lat[1] != 99) break;
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) chk("res_latency", lat[k], (n == 0) ? 0 : k + 1);
        for (int h = 0; h < hold; h++) begin
            start = inject;
            len   = 8'd1;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("res_valid_hold", res_valid[k], 1);
                chk("op_ready_hold", op_ready[k], 0);
            end
        end
        start     = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 2; k++) chk("res_data", res_data[k], exp_q[0]);
        void'(exp_q.pop_front());
        @(negedge clk);
        res_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("res_valid_after", res_valid[k], 0);
            chk("busy_after", busy[k], 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0; op_x = '0; op_y = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_op_ready", op_ready[k], 0);
            chk("rst_res_valid", res_valid[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_cep", apm_cep[k], 0);
            chk("rst_rstp", apm_rstp[k], 1);
            chk("rst_p", apm_p[k], 0);
            chk("const_cem", apm_cem[k], 1);
            chk("const_modey", apm_modey[k], 3'b001);
            chk("const_modein", apm_modein[k], 5'b00010);
        end
        rst = 1'b0;
        @(negedge clk);
        jx[0] = 25'd2; jy[0] = 18'd3;
        jx[1] = -25'sd4; jy[1] = 18'd5;
        jx[2] = 25'd7; jy[2] = -18'sd1;
        run_job(3, 0, 0, 1'b0);
        run_job(3, 2, 0, 1'b0);
        run_job(0, 0, 0, 1'b0);
        jx[0] = 25'd1; jy[0] = 18'd1;
        run_job(1, 0, 0, 1'b0);
        jx[0] = 25'd3; jy[0] = 18'd3;
        run_job(1, 0, 5, 1'b1);
        start = 1'b1; len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_valid = 1'b1; op_x = 25'd5; op_y = 18'd5;
            @(negedge clk);
        end
        op_valid = 1'b0;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_busy", busy[k], 0);
            chk("midrst_op_ready", op_ready[k], 0);
            chk("midrst_cep", apm_cep[k], 0);
            chk("midrst_rstp", apm_rstp[k], 1);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("midrst_p", apm_p[k], 0);
            chk("midrst_res_valid", res_valid[k], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        jx[0] = 25'd5; jy[0] = -18'sd6;
        run_job(1, 0, 0, 1'b0);
        jx[0] = 25'h0FFFFFF; jy[0] = 18'h1FFFF;
        jx[1] = 25'h0FFFFFF; jy[1] = 18'h1FFFF;
        run_job(2, 0, 0, 1'b0);
        jx[0] = 25'h1000000; jy[0] = 18'h20000;
        jx[1] = 25'h1000000; jy[1] = 18'h20000;
        jx[2] = 25'h1000000; jy[2] = 18'h20000;
        run_job(3, 1, 0, 1'b0);
        chk("scoreboard_empty", 48'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
